// File: rtl/jtag_tap_driver.sv
// jtag_tap_driver
//   JTAG host: turns one command (TAP reset, IR scan, DR scan <= 32 bits)
//   into a TCK/TMS/TDI sequence and returns the TDO bits captured during the
//   shift, right-aligned.
// Ports
//   clk_i, trst_ni                 system clock, async active-low reset
//   req_valid_i/req_ready_o        command handshake (ready only in IDLE)
//   req_op_i/req_len_i/req_data_i  op (00/11 reset, 01 IR, 10 DR), DR length,
//                                  TDI bits LSB first
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_data_o                     captured TDO bits
//   tck_o/tms_o/tdi_o/tdo_i        JTAG pins
module jtag_tap_driver #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned IR_WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        trst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [5:0]  req_len_i,
  input  logic [31:0] req_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
);
  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [4:0]    IR_LAST  = 5'(IR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_NAV, S_SHIFT, S_EXIT, S_RESP
  } state_e;

  state_e        state_q, nxt_state;
  logic [DW-1:0] div_q;
  logic [4:0]    cnt_q, nxt_cnt, last_q, req_last;
  logic          op_reset_q, is_ir_q, synced_q, nxt_synced;
  logic          nxt_tms, nxt_tdi, req_is_rst;
  logic [31:0]   data_q;

  assign req_is_rst = (req_op_i == 2'b00) || (req_op_i == 2'b11);

  // Shift count minus one; out-of-range DR lengths collapse to 32.
  always_comb begin
    if (req_op_i == 2'b01)
      req_last = IR_LAST;
    else if (req_len_i == 6'd0 || req_len_i > 6'd32)
      req_last = 5'd31;
    else
      req_last = 5'(req_len_i - 6'd1);
  end

  // Position (state, cnt) reached after the current TCK completes, and the
  // TMS/TDI to present for that position's TCK.
  always_comb begin
    nxt_state  = state_q;
    nxt_cnt    = cnt_q + 5'd1;
    nxt_synced = synced_q;
    case (state_q)
      S_RESET: if (cnt_q == 5'd5) begin
        nxt_cnt    = 5'd0;
        nxt_synced = 1'b1;
        nxt_state  = op_reset_q ? S_RESP : S_NAV;
      end
      S_NAV:   if (cnt_q == (is_ir_q ? 5'd3 : 5'd2)) begin
        nxt_cnt   = 5'd0;
        nxt_state = S_SHIFT;
      end
      S_SHIFT: if (cnt_q == last_q) begin
        nxt_cnt   = 5'd0;
        nxt_state = S_EXIT;
      end
      S_EXIT:  if (cnt_q == 5'd1) begin
        nxt_cnt   = 5'd0;
        nxt_state = S_RESP;
      end
      default: ;
    endcase

    nxt_tms = 1'b0;
    nxt_tdi = 1'b0;
    case (nxt_state)
      S_RESET: nxt_tms = (nxt_cnt != 5'd5);                        // 5x1 then 0
      S_NAV:   nxt_tms = is_ir_q ? (nxt_cnt < 5'd2) : (nxt_cnt == 5'd0);
      S_SHIFT: begin
        nxt_tms = (nxt_cnt == last_q);                             // last bit -> Exit1
        nxt_tdi = data_q[nxt_cnt];
      end
      S_EXIT:  nxt_tms = (nxt_cnt == 5'd0);                        // Update, then RTI
      default: ;                                                   // parked in RTI
    endcase
  end

  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      op_reset_q  <= 1'b0;
      is_ir_q     <= 1'b0;
      synced_q    <= 1'b0;
      data_q      <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      tck_o       <= 1'b0;
      tms_o       <= 1'b1;
      tdi_o       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          req_ready_o <= 1'b0;
          op_reset_q  <= req_is_rst;
          is_ir_q     <= (req_op_i == 2'b01);
          last_q      <= req_last;
          data_q      <= req_data_i;
          rsp_data_o  <= '0;
          cnt_q       <= '0;
          div_q       <= '0;
          tck_o       <= 1'b0;
          // First TCK of both RESET and NAV carries TMS=1.
          tms_o       <= 1'b1;
          tdi_o       <= 1'b0;
          state_q     <= (req_is_rst || !synced_q) ? S_RESET : S_NAV;
        end
        S_RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            tck_o <= ~tck_o;
            if (!tck_o) begin
              // Rising TCK: TDO was driven by the target at the last fall.
              if (state_q == S_SHIFT) rsp_data_o[cnt_q] <= tdo_i;
            end else begin
              // Falling TCK: start the next low phase with new TMS/TDI.
              state_q  <= nxt_state;
              cnt_q    <= nxt_cnt;
              synced_q <= nxt_synced;
              tms_o    <= nxt_tms;
              tdi_o    <= nxt_tdi;
              if (nxt_state == S_RESP) rsp_valid_o <= 1'b1;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
      endcase
    end
  end

endmodule
